mem_ctrl_ram: RTL and testbench

- Parametrised single-port synchronous RAM with a request/ready handshake, per-byte write enables, selectable read latency, and an initialisation sweep.
- Successor to the team's fixed 4x8 memory block.
- Sits between bus-side logic and local storage in the memory-integration subsystem.
- Clears its own contents after reset, and on demand, so no downstream block ever reads undefined data.

---
 rtl/mem_ctrl_pkg.sv | 21 ++
 rtl/mem_ctrl_array.sv | 34 +++
 rtl/mem_ctrl_ram.sv | 166 ++++++++++++++++
 tb/tb_mem_ctrl_ram.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the byte-enabled RAM controller.
package mem_ctrl_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_INIT  = 2'd1,
        ST_IDLE  = 2'd2
    } state_e;

    // Number of byte lanes (BE_WIDTH) for a given word width.
    function automatic int unsigned be_width(input int unsigned word_width);
        return word_width / BYTE_W;
    endfunction

    function automatic bit rd_latency_ok(input int unsigned lat);
        return (lat == 1) || (lat == 2);
    endfunction

endpackage

// File: rtl/mem_ctrl_array.sv
// Byte-enabled single-port storage with a registered read port; contents are not reset.
module mem_ctrl_array
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned WORD_DEPTH = 16,
    parameter int unsigned WORD_WIDTH = 32
) (
    input  logic                                clk,
    input  logic                                wr_en,
    input  logic                                rd_en,
    input  logic [ADDR_WIDTH-1:0]               addr,
    input  logic [be_width(WORD_WIDTH)-1:0]     be,
    input  logic [WORD_WIDTH-1:0]               wdata,
    output logic [WORD_WIDTH-1:0]               rdata
);

    localparam int unsigned BE_W = be_width(WORD_WIDTH);

    logic [WORD_WIDTH-1:0] mem_q [WORD_DEPTH];
    logic [WORD_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be[i]) mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (rd_en) rdata_q <= mem_q[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_ctrl_ram.sv
// Single-port RAM controller: reset/on-demand clear sweep, request/ready access,
// range checking and a 1- or 2-cycle read pipeline in front of mem_ctrl_array.
module mem_ctrl_ram
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned            ADDR_WIDTH    = 4,
    parameter int unsigned            WORD_DEPTH    = 16,
    parameter int unsigned            WORD_WIDTH    = 32,
    parameter int unsigned            RD_LATENCY    = 1,
    parameter bit                     INIT_ON_RESET = 1'b1,
    parameter logic [WORD_WIDTH-1:0]  INIT_VALUE    = '0
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            init_req,
    input  logic                            req,
    input  logic                            we,
    input  logic [ADDR_WIDTH-1:0]           adrs,
    input  logic [be_width(WORD_WIDTH)-1:0] be,
    input  logic [WORD_WIDTH-1:0]           d_in,
    output logic                            ready,
    output logic                            rd_valid,
    output logic [WORD_WIDTH-1:0]           d_out,
    output logic                            err,
    output logic                            init_busy
);

    localparam int unsigned BE_W = be_width(WORD_WIDTH);

    if (!rd_latency_ok(RD_LATENCY)) begin : g_bad_latency
        $error("mem_ctrl_ram: RD_LATENCY must be 1 or 2");
    end
    if ((WORD_WIDTH % 8) != 0 || WORD_DEPTH > (2 ** ADDR_WIDTH)) begin : g_bad_geometry
        $error("mem_ctrl_ram: illegal WORD_WIDTH or WORD_DEPTH");
    end

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  cnt_q, cnt_d;
    logic                   ready_q, ready_d;
    logic                   init_busy_q, init_busy_d;
    logic                   rv1_q, rv1_d;
    logic                   roob1_q, roob1_d;
    logic                   zero1_q, zero1_d;
    logic                   err_q, err_d;

    logic                   sweep_c, accept_c, in_range_c, wr_acc_c, rd_acc_c;
    logic                   arr_we_c, arr_re_c;
    logic [ADDR_WIDTH-1:0]  arr_addr_c;
    logic [BE_W-1:0]        arr_be_c;
    logic [WORD_WIDTH-1:0]  arr_wdata_c, arr_rdata, d1_c;

    // Next-state logic; ready/init_busy are registered copies of the next state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RESET: state_d = INIT_ON_RESET ? ST_INIT : ST_IDLE;
            ST_INIT: begin
                cnt_d = cnt_q + ADDR_WIDTH'(1);
                if (cnt_q == ADDR_WIDTH'(WORD_DEPTH - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            ST_IDLE: begin
                if (init_req) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_RESET;
        endcase
        ready_d     = (state_d == ST_IDLE);
        init_busy_d = (state_d == ST_INIT);
    end

    // Access qualification; init_req beats a simultaneous request.
    always_comb begin
        sweep_c     = (state_q == ST_INIT);
        accept_c    = req & ready_q & ~init_req;
        in_range_c  = {1'b0, adrs} < (ADDR_WIDTH + 1)'(WORD_DEPTH);
        wr_acc_c    = accept_c & we;
        rd_acc_c    = accept_c & ~we;
        arr_we_c    = sweep_c | (wr_acc_c & in_range_c);
        arr_re_c    = rd_acc_c & in_range_c;
        arr_addr_c  = sweep_c ? cnt_q : adrs;
        arr_be_c    = sweep_c ? '1 : be;
        arr_wdata_c = sweep_c ? INIT_VALUE : d_in;
    end

    // First read stage; zero1 forces 0 for out-of-range reads and after reset.
    always_comb begin
        rv1_d   = rd_acc_c;
        roob1_d = rd_acc_c & ~in_range_c;
        zero1_d = rd_acc_c ? ~in_range_c : zero1_q;
        err_d   = (wr_acc_c & ~in_range_c) | ((RD_LATENCY == 1) ? roob1_d : roob1_q);
        d1_c    = zero1_q ? '0 : arr_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RESET;
            cnt_q       <= '0;
            ready_q     <= 1'b0;
            init_busy_q <= 1'b0;
            rv1_q       <= 1'b0;
            roob1_q     <= 1'b0;
            zero1_q     <= 1'b1;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ready_q     <= ready_d;
            init_busy_q <= init_busy_d;
            rv1_q       <= rv1_d;
            roob1_q     <= roob1_d;
            zero1_q     <= zero1_d;
            err_q       <= err_d;
        end
    end

    mem_ctrl_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .WORD_DEPTH (WORD_DEPTH),
        .WORD_WIDTH (WORD_WIDTH)
    ) u_array (
        .clk   (clk),
        .wr_en (arr_we_c),
        .rd_en (arr_re_c),
        .addr  (arr_addr_c),
        .be    (arr_be_c),
        .wdata (arr_wdata_c),
        .rdata (arr_rdata)
    );

    if (RD_LATENCY == 2) begin : g_lat2
        logic                  rv2_q, rv2_d;
        logic [WORD_WIDTH-1:0] d2_q, d2_d;

        always_comb begin
            rv2_d = rv1_q;
            d2_d  = rv1_q ? d1_c : d2_q;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rv2_q <= 1'b0;
                d2_q  <= '0;
            end else begin
                rv2_q <= rv2_d;
                d2_q  <= d2_d;
            end
        end

        assign rd_valid = rv2_q;
        assign d_out    = d2_q;
    end else begin : g_lat1
        assign rd_valid = rv1_q;
        assign d_out    = d1_c;
    end

    assign ready     = ready_q;
    assign init_busy = init_busy_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_ctrl_ram.sv
// Scoreboard bench: two configurations (16 words/latency 1, 12 words/latency 2)
// driven with directed and random traffic against an array-based reference model.
module tb_mem_ctrl_ram;

    typedef struct {
        bit          rd;
        bit          oob;
        logic [31:0] d;
        int          cyc;
    } item_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        init_req [2];
    logic        req      [2];
    logic        we       [2];
    logic [3:0]  adrs     [2];
    logic [3:0]  be_i     [2];
    logic [31:0] din      [2];
    logic        rdy      [2];
    logic        vld      [2];
    logic [31:0] dout     [2];
    logic        err_o    [2];
    logic        busy_o   [2];

    int          depth [2] = '{16, 12};
    int          lat   [2] = '{1, 2};
    logic [31:0] initv [2] = '{32'h0000_0000, 32'h5A5A_A5A5};

    logic [31:0] mm     [2][16];
    logic [31:0] last_d [2];
    item_t       sb     [2][$];
    int          cyc = 0;
    int          errs = 0;
    int          checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_ctrl_ram #(
        .ADDR_WIDTH(4), .WORD_DEPTH(16), .WORD_WIDTH(32), .RD_LATENCY(1),
        .INIT_ON_RESET(1'b1), .INIT_VALUE(32'h0000_0000)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .init_req(init_req[0]), .req(req[0]), .we(we[0]),
        .adrs(adrs[0]), .be(be_i[0]), .d_in(din[0]), .ready(rdy[0]), .rd_valid(vld[0]),
        .d_out(dout[0]), .err(err_o[0]), .init_busy(busy_o[0])
    );

    mem_ctrl_ram #(
        .ADDR_WIDTH(4), .WORD_DEPTH(12), .WORD_WIDTH(32), .RD_LATENCY(2),
        .INIT_ON_RESET(1'b1), .INIT_VALUE(32'h5A5A_A5A5)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .init_req(init_req[1]), .req(req[1]), .we(we[1]),
        .adrs(adrs[1]), .be(be_i[1]), .d_in(din[1]), .ready(rdy[1]), .rd_valid(vld[1]),
        .d_out(dout[1]), .err(err_o[1]), .init_busy(busy_o[1])
    );

    task automatic chk(input bit ok, input string name, input int k,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errs++;
            $display("FAIL %s dut%0d @cyc %0d: got %h expected %h", name, k, cyc, act, exp);
        end
    endtask

    task automatic idle(input int k);
        init_req[k] = 1'b0;
        req[k]      = 1'b0;
        we[k]       = 1'b0;
        adrs[k]     = 4'h0;
        be_i[k]     = 4'h0;
        din[k]      = 32'h0;
    endtask

    // Reference: words are plain array entries, the sweep fills every legal word.
    task automatic model_fill(input int k);
        for (int i = 0; i < 16; i++) mm[k][i] = (i < depth[k]) ? initv[k] : 32'h0;
    endtask

    // One request in the cycle ending at the next rising edge; the model is updated in issue order.
    task automatic op(input int k, input bit w, input logic [3:0] a,
                      input logic [3:0] b, input logic [31:0] d);
        item_t it;
        req[k] = 1'b1; we[k] = w; adrs[k] = a; be_i[k] = b; din[k] = d;
        it.oob = (int'(a) >= depth[k]);
        it.rd  = !w;
        it.d   = 32'h0;
        if (w) begin
            it.cyc = cyc + 1;
            if (it.oob) sb[k].push_back(it);
            else for (int i = 0; i < 4; i++) if (b[i]) mm[k][a][8*i +: 8] = d[8*i +: 8];
        end else begin
            it.cyc = cyc + lat[k];
            if (!it.oob) it.d = mm[k][a];
            sb[k].push_back(it);
        end
        @(posedge clk); #1;
        idle(k);
    endtask

    // Counts init_busy cycles and locates the first ready cycle, then realigns to posedge+1.
    task automatic sweep_check(input int k, input int n, input int pre);
        int busy_n = 0;
        int idx = -1;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (rdy[k]) begin
                idx = i;
                break;
            end
            if (busy_o[k]) busy_n++;
        end
        idle(k);
        chk(idx == n + pre, "ready_rise_cycle", k, 32'(idx), 32'(n + pre));
        chk(busy_n == n, "init_busy_len", k, 32'(busy_n), 32'(n));
        chk(busy_o[k] == 1'b0, "busy_at_ready", k, 32'(busy_o[k]), 32'h0);
        @(posedge clk); #1;
    endtask

    // init_req pulse, optionally colliding with a read that must be refused.
    task automatic init_pulse(input int k, input bit with_req, input logic [3:0] a);
        init_req[k] = 1'b1;
        if (with_req) begin
            req[k] = 1'b1; we[k] = 1'b0; adrs[k] = a;
        end
        @(posedge clk); #1;
        init_req[k] = 1'b0;
        model_fill(k);
        sweep_check(k, depth[k], 0);
    endtask

    task automatic rand_phase(input int k, input int n);
        bit prev_rd = 1'b0;
        for (int i = 0; i < n; i++) begin
            int unsigned r = $urandom_range(0, 99);
            if (r < 8) begin
                @(posedge clk); #1;
                prev_rd = 1'b0;
            end else if (r < 10) begin
                init_pulse(k, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
                prev_rd = 1'b0;
            end else begin
                bit         w = 1'($urandom_range(0, 1));
                logic [3:0] a = 4'($urandom_range(0, 15));
                // keep a write error from sharing a cycle with an earlier read's response
                if (w && prev_rd && lat[k] == 2 && int'(a) >= depth[k]) begin
                    @(posedge clk); #1;
                end
                op(k, w, a, 4'($urandom_range(0, 15)), $urandom);
                prev_rd = !w;
            end
        end
    endtask

    task automatic mon(input int k);
        item_t       it;
        bit          ev = 1'b0;
        bit          ee = 1'b0;
        logic [31:0] ed;
        if (!rst_n) begin
            chk(rdy[k] == 1'b0, "rst_ready", k, 32'(rdy[k]), 32'h0);
            chk(vld[k] == 1'b0, "rst_rd_valid", k, 32'(vld[k]), 32'h0);
            chk(dout[k] == 32'h0, "rst_d_out", k, dout[k], 32'h0);
            chk(err_o[k] == 1'b0, "rst_err", k, 32'(err_o[k]), 32'h0);
            chk(busy_o[k] == 1'b0, "rst_init_busy", k, 32'(busy_o[k]), 32'h0);
            sb[k].delete();
            last_d[k] = 32'h0;
            return;
        end
        ed = last_d[k];
        while (sb[k].size() > 0 && sb[k][0].cyc <= cyc) begin
            it = sb[k].pop_front();
            if (it.rd) begin
                ev = 1'b1;
                ed = it.d;
            end
            if (it.oob) ee = 1'b1;
        end
        if (ev || vld[k]) chk(vld[k] == ev, "rd_valid", k, 32'(vld[k]), 32'(ev));
        chk(dout[k] == ed, "d_out", k, dout[k], ed);
        if (ee || err_o[k]) chk(err_o[k] == ee, "err", k, 32'(err_o[k]), 32'(ee));
        last_d[k] = ed;
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) mon(k);
    end

    initial begin
        idle(0);
        idle(1);
        last_d[0] = 32'h0;
        last_d[1] = 32'h0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_fill(0);
        model_fill(1);
        fork
            sweep_check(0, 16, 1);
            sweep_check(1, 12, 1);
        join

        // cleared word, then byte-enable merge with read-after-write
        op(0, 1'b0, 4'd5, 4'h0, 32'h0);
        op(0, 1'b1, 4'd3, 4'hF, 32'hDEAD_BEEF);
        op(0, 1'b1, 4'd3, 4'h2, 32'h0000_1100);
        op(0, 1'b0, 4'd3, 4'h0, 32'h0);

        // latency-2 back-to-back reads
        op(1, 1'b1, 4'd0, 4'hF, 32'hA);
        op(1, 1'b1, 4'd1, 4'hF, 32'hB);
        op(1, 1'b1, 4'd2, 4'hF, 32'hC);
        op(1, 1'b0, 4'd0, 4'h0, 32'h0);
        op(1, 1'b0, 4'd1, 4'h0, 32'h0);
        op(1, 1'b0, 4'd2, 4'h0, 32'h0);
        repeat (4) begin @(posedge clk); #1; end

        // out-of-range write and read on the 12-word instance, alias word untouched
        op(1, 1'b1, 4'd13, 4'hF, 32'h55);
        op(1, 1'b0, 4'd13, 4'h0, 32'h0);
        op(1, 1'b0, 4'd1, 4'h0, 32'h0);
        repeat (4) begin @(posedge clk); #1; end

        // on-demand clear with a blocked request during the sweep
        op(0, 1'b1, 4'd7, 4'hF, 32'h1234);
        init_pulse(0, 1'b1, 4'd7);
        op(0, 1'b0, 4'd7, 4'h0, 32'h0);
        repeat (3) begin @(posedge clk); #1; end

        // reset mid-sweep (cnt=6 on A) with a read in flight on B
        init_req[0] = 1'b1;
        @(posedge clk); #1;
        init_req[0] = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        op(1, 1'b0, 4'd2, 4'h0, 32'h0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_fill(0);
        model_fill(1);
        fork
            sweep_check(0, 16, 1);
            sweep_check(1, 12, 1);
        join

        rand_phase(0, 300);
        rand_phase(1, 300);

        repeat (6) begin @(posedge clk); #1; end
        for (int k = 0; k < 2; k++)
            chk(sb[k].size() == 0, "pending_responses", k, 32'(sb[k].size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
